restore_div_sched: RTL and testbench

RESTORE_DIV_SCHED -- requirements
Module: restore_div_sched

---
 rtl/div_pkg.sv | 12 +
 rtl/restore_div_step.sv | 62 ++++++
 rtl/restore_div_sched.sv | 147 ++++++++++++++
 tb/tb_restore_div_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring-divider scheduler.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned NUM_REQ = 2;

endpackage

// File: rtl/restore_div_step.sv
// Single-step unsigned restoring divider datapath: p (partial remainder),
// a (dividend shifting into quotient), b (divisor). One step per enable.
module restore_div_step #(
  parameter int unsigned n = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] p_nxt_o,
  output logic [n-1:0] a_nxt_o
);

  logic [n-1:0] p_q, p_d;
  logic [n-1:0] a_q, a_d;
  logic [n-1:0] b_q, b_d;
  logic [n:0]   p_sh;
  logic [n-1:0] diff;
  logic         ge;

  // One restoring step from the current registers; also selects load/step/hold.
  always_comb begin
    p_sh = {p_q, a_q[n-1]};
    ge   = (p_sh >= {1'b0, b_q});
    // When the subtraction succeeds the result is below b, so n bits are exact.
    diff = p_sh[n-1:0] - b_q;
    if (ge) begin
      p_nxt_o = diff;
      a_nxt_o = {a_q[n-2:0], 1'b1};
    end else begin
      p_nxt_o = p_sh[n-1:0];
      a_nxt_o = {a_q[n-2:0], 1'b0};
    end
    p_d = p_q;
    a_d = a_q;
    b_d = b_q;
    if (load) begin
      p_d = '0;
      a_d = a_i;
      b_d = b_i;
    end else if (en) begin
      p_d = p_nxt_o;
      a_d = a_nxt_o;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      p_q <= p_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/restore_div_sched.sv
// Two-requester round-robin front end for a signed restoring divider.
// Optional macro RESTORE_DIV_SCHED_ZERO_BYPASS_EN: divide-by-zero skips CALC
// and responds one cycle after accept.
module restore_div_sched
  import div_pkg::*;
#(
  parameter int unsigned n = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [n-1:0]       Dividend0,
  input  logic [n-1:0]       Divisor0,
  input  logic [n-1:0]       Dividend1,
  input  logic [n-1:0]       Divisor1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [n-1:0]       Quotient,
  output logic [n-1:0]       Remainder,
  output logic               div_zero,
  output logic               busy
);

  localparam int unsigned CW = $clog2(n);

  div_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         rr_q, rr_d;
  logic         id_q, id_d;
  logic         qneg_q, qneg_d;
  logic         rneg_q, rneg_d;
  logic         dz_q, dz_d;
  logic [n-1:0] quot_q, quot_d;
  logic [n-1:0] rem_q, rem_d;

  logic         gnt_id;
  logic         accept;
  logic [n-1:0] dvd_sel, dvs_sel, dvd_mag, dvs_mag;
  logic [n-1:0] p_nxt, a_nxt;

  // Arbitration, operand selection and magnitude conversion.
  always_comb begin
    req_ready = '0;
    gnt_id    = rr_q;
    if (req_valid[0] && !req_valid[1]) gnt_id = 1'b0;
    else if (req_valid[1] && !req_valid[0]) gnt_id = 1'b1;
    if (state_q == IDLE && !reset && (req_valid != '0)) req_ready[gnt_id] = 1'b1;
    accept  = |(req_valid & req_ready);
    dvd_sel = gnt_id ? Dividend1 : Dividend0;
    dvs_sel = gnt_id ? Divisor1  : Divisor0;
    dvd_mag = dvd_sel[n-1] ? -dvd_sel : dvd_sel;
    dvs_mag = dvs_sel[n-1] ? -dvs_sel : dvs_sel;
  end

  restore_div_step #(.n(n)) u_step (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .en      (state_q == CALC),
    .a_i     (dvd_mag),
    .b_i     (dvs_mag),
    .p_nxt_o (p_nxt),
    .a_nxt_o (a_nxt)
  );

  // FSM next state, iteration count and result sign fix-up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    id_d    = id_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rr_d    = ~gnt_id;
          id_d    = gnt_id;
          qneg_d  = dvd_sel[n-1] ^ dvs_sel[n-1];
          rneg_d  = dvd_sel[n-1];
          dz_d    = (dvs_sel == '0);
          cnt_d   = '0;
          state_d = CALC;
`ifdef RESTORE_DIV_SCHED_ZERO_BYPASS_EN
          if (dvs_sel == '0) begin
            quot_d  = '1;
            rem_d   = dvd_sel;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(n - 1)) begin
          // Final step result is taken combinationally so DONE lands n cycles later.
          state_d = DONE;
          cnt_d   = '0;
          quot_d  = dz_q ? '1 : (qneg_q ? -a_nxt : a_nxt);
          rem_d   = rneg_q ? -p_nxt : p_nxt;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign div_zero  = dz_q & rsp_valid;

endmodule

// File: tb/tb_restore_div_sched.sv
// Self-checking bench for restore_div_sched (n=8): directed cases plus
// randomized two-requester traffic against a behavioural model.
module tb_restore_div_sched;

  localparam int N = 8;
`ifdef RESTORE_DIV_SCHED_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [N-1:0] Dividend0, Divisor0, Dividend1, Divisor1;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [N-1:0] Quotient, Remainder;
  logic         div_zero, busy;

  int passed = 0;
  int total  = 0;

  restore_div_sched #(.n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .Dividend0 (Dividend0),
    .Divisor0  (Divisor0),
    .Dividend1 (Dividend1),
    .Divisor1  (Divisor1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  // Signed division as the spec defines it, using plain integer arithmetic.
  function automatic void model_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    if (sb == 0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80; r = 8'h00;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
    end
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  logic       m_busy = 1'b0;
  logic       m_rr   = 1'b0;
  logic       m_id   = 1'b0;
  logic [7:0] m_q, m_r;
  logic       m_dz;
  int         m_due  = 0;
  int         cyc    = 0;
  int         rsp_cnt = 0;

  // Compare DUT against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    logic [1:0] er;
    logic       ev;
    logic       k;
    logic [7:0] a, b;
    er = 2'b00;
    if (!reset && !m_busy && req_valid != 2'b00)
      er = (req_valid == 2'b11) ? (m_rr ? 2'b10 : 2'b01) : req_valid;
    chk("req_ready", req_ready, er);
    chk("busy", busy, m_busy);
    ev = m_busy && (cyc >= m_due);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, m_id);
      chk("Quotient", Quotient, m_q);
      chk("Remainder", Remainder, m_r);
      chk("div_zero", div_zero, m_dz);
    end
    if (reset) begin
      m_busy = 1'b0;
      m_rr   = 1'b0;
    end else if (m_busy) begin
      if (ev && rsp_ready) begin
        m_busy = 1'b0;
        rsp_cnt++;
      end
    end else if (er != 2'b00) begin
      k    = er[1];
      a    = k ? Dividend1 : Dividend0;
      b    = k ? Divisor1  : Divisor0;
      model_div(a, b, m_q, m_r, m_dz);
      m_id   = k;
      m_rr   = ~k;
      m_due  = cyc + ((b == 8'h00) ? ZLAT : N + 1);
      m_busy = 1'b1;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ops(input int k, input logic [7:0] a, input logic [7:0] b);
    if (k == 0) begin Dividend0 = a; Divisor0 = b; end
    else        begin Dividend1 = a; Divisor1 = b; end
  endtask

  function automatic logic [7:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic wait_accept(input int k, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[k];
    end
  endtask

  task automatic wait_rsp(output int lat, output logic ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      lat++;
      ok = rsp_valid;
    end
  endtask

  task automatic run_one(input string tag, input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int elat, input int hold);
    logic ok;
    int   lat;
    @(posedge clk); #1;
    rsp_ready = (hold == 0);
    set_ops(k, a, b);
    req_valid[k] = 1'b1;
    wait_accept(k, ok);
    chk({tag, " accept"}, ok, 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    set_ops(k, 8'($urandom), 8'($urandom));
    wait_rsp(lat, ok);
    chk({tag, " rsp seen"}, ok, 1);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " Quotient"}, Quotient, eq);
    chk({tag, " Remainder"}, Remainder, er);
    chk({tag, " div_zero"}, div_zero, edz);
    chk({tag, " rsp_id"}, rsp_id, k);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, rsp_valid, 1);
      chk({tag, " hold Quotient"}, Quotient, eq);
      chk({tag, " hold Remainder"}, Remainder, er);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] q, r;
    logic       dz, ok;
    logic [1:0] acc;
    int         lat;

    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    Dividend0 = '0; Divisor0 = '0; Dividend1 = '0; Divisor1 = '0;

    // Pin the model with hand-computed values.
    model_div(8'd100, 8'd7, q, r, dz);
    chk("model 100/7 q", q, 8'd14);  chk("model 100/7 r", r, 8'd2);
    model_div(8'h9C, 8'd7, q, r, dz);
    chk("model -100/7 q", q, 8'hF2); chk("model -100/7 r", r, 8'hFE);
    model_div(8'd5, 8'd0, q, r, dz);
    chk("model 5/0 q", q, 8'hFF);    chk("model 5/0 dz", dz, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset Quotient", Quotient, 0);
    chk("reset Remainder", Remainder, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset div_zero", div_zero, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_one("100/7",    0, 8'd100, 8'd7,  8'd14,  8'd2,  1'b0, N + 1, 0);
    run_one("-100/7",   0, 8'h9C,  8'd7,  8'hF2,  8'hFE, 1'b0, N + 1, 0);
    run_one("100/-7",   1, 8'd100, 8'hF9, 8'hF2,  8'd2,  1'b0, N + 1, 0);

    // Both requesters valid together with rr_ptr back at 0.
    @(posedge clk); #1;
    set_ops(0, 8'd50, 8'd3);
    set_ops(1, 8'd77, 8'hFB);
    req_valid = 2'b11;
    wait_accept(0, ok);
    chk("both first grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(lat, ok);
    chk("both rsp0 id", rsp_id, 0);
    chk("both rsp0 q", Quotient, 8'd16);
    wait_accept(1, ok);
    chk("both second grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(lat, ok);
    chk("both rsp1 id", rsp_id, 1);
    chk("both rsp1 q", Quotient, 8'hF1);
    chk("both rsp1 r", Remainder, 8'd2);

    run_one("5/0",      0, 8'd5,   8'd0,  8'hFF,  8'd5,  1'b1, ZLAT, 0);
    run_one("-128/-1",  0, 8'h80,  8'hFF, 8'h80,  8'd0,  1'b0, N + 1, 3);

    // Reset during the fourth CALC cycle.
    @(posedge clk); #1;
    set_ops(0, 8'd55, 8'd6);
    req_valid[0] = 1'b1;
    wait_accept(0, ok);
    chk("rst accept", ok, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst no rsp", rsp_valid, 0);
    end
    run_one("post-rst 33/4", 0, 8'd33, 8'd4, 8'd8, 8'd1, 1'b0, N + 1, 0);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          req_valid[k] = 1'b0;
          set_ops(k, rand_op(), rand_op());
        end else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
          set_ops(k, rand_op(), rand_op());
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end

    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (25) @(negedge clk);
    chk("random responses seen", rsp_cnt > 40, 1);
    chk("drained idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
